// File: rtl/panda_pkg.sv
// panda_pkg: shared load/store unit types
package panda_pkg;
  typedef enum logic [1:0] {LSU_BYTE = 2'd0, LSU_HALF = 2'd1, LSU_WORD = 2'd2} lsu_width_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3} lsu_state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_MISALIGNED = 2'd1, ERR_BUS = 2'd2, ERR_TIMEOUT = 2'd3} lsu_err_e;
endpackage

// File: rtl/panda_lsu_align.sv
// panda_lsu_align: byte-lane steering, misalignment detect and load extension
module panda_lsu_align
  import panda_pkg::*;
(
  input  lsu_width_e  width,
  input  logic        load_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);
  logic [31:0] shifted;
  logic        sx;
  always_comb begin
    misaligned = (width == LSU_HALF) ? offset[0] : (width == LSU_WORD) ? |offset : 1'b0;
    be = (width == LSU_BYTE) ? 4'b0001 << offset
       : (width == LSU_HALF) ? 4'b0011 << {offset[1], 1'b0} : 4'b1111;
    wdata_lane = (width == LSU_BYTE) ? {4{wdata[7:0]}}
               : (width == LSU_HALF) ? {2{wdata[15:0]}} : wdata;
    shifted = rdata >> {offset, 3'b000};
    sx = ~load_unsigned;
    rdata_ext = (width == LSU_BYTE) ? {{24{sx & shifted[7]}}, shifted[7:0]}
              : (width == LSU_HALF) ? {{16{sx & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/panda_lsu_bus.sv
// panda_lsu_bus: stallable request/grant/response load/store unit
module panda_lsu_bus
  import panda_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_store_i,
  input  lsu_width_e           lsu_width_i,
  input  logic                 lsu_load_unsigned_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [31:0]          lsu_wdata_i,
  output logic [31:0]          lsu_rdata_o,
  output logic                 lsu_done_o,
  output logic                 lsu_stall_o,
  output logic                 lsu_err_o,
  output lsu_err_e             lsu_err_cause_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i,
  input  logic                 data_err_i
);
  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  lsu_state_e    state, state_n;
  lsu_err_e      cause_n;
  logic [CW-1:0] cnt;
  logic          expired, misaligned;
  logic [3:0]    be;
  logic [31:0]   wdata_lane, rdata_ext;
  panda_lsu_align u_align (
    .width        (lsu_width_i),
    .load_unsigned(lsu_load_unsigned_i),
    .offset       (lsu_addr_i[1:0]),
    .wdata        (lsu_wdata_i),
    .rdata        (data_rdata_i),
    .misaligned   (misaligned),
    .be           (be),
    .wdata_lane   (wdata_lane),
    .rdata_ext    (rdata_ext)
  );
  // expired marks the last permitted REQ/WAIT cycle; it outranks grant and response
  assign expired = (TimeoutCycles != 0) && (cnt == LAST);
  assign lsu_stall_o = lsu_req_i & ~lsu_done_o;
  always_comb begin
    state_n = state;
    cause_n = ERR_NONE;
    case (state)
      ST_IDLE: if (lsu_req_i) begin
        state_n = misaligned ? ST_DONE : ST_REQ;
        cause_n = misaligned ? ERR_MISALIGNED : ERR_NONE;
      end
      ST_REQ: if (expired) begin
        state_n = ST_DONE;
        cause_n = ERR_TIMEOUT;
      end else if (data_gnt_i) state_n = ST_WAIT;
      ST_WAIT: if (expired) begin
        state_n = ST_DONE;
        cause_n = ERR_TIMEOUT;
      end else if (data_rvalid_i) begin
        state_n = ST_DONE;
        cause_n = data_err_i ? ERR_BUS : ERR_NONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      data_req_o      <= 1'b0;
      data_we_o       <= 1'b0;
      data_be_o       <= '0;
      data_addr_o     <= '0;
      data_wdata_o    <= '0;
      lsu_rdata_o     <= '0;
      lsu_done_o      <= 1'b0;
      lsu_err_o       <= 1'b0;
      lsu_err_cause_o <= ERR_NONE;
    end else begin
      state           <= state_n;
      cnt             <= (state == ST_REQ || state == ST_WAIT) ? cnt + CW'(1) : '0;
      data_req_o      <= state_n == ST_REQ;
      lsu_done_o      <= state_n == ST_DONE;
      lsu_err_o       <= (state_n == ST_DONE) && (cause_n != ERR_NONE);
      lsu_err_cause_o <= cause_n;
      if (state == ST_IDLE && state_n == ST_REQ) begin
        data_addr_o  <= {lsu_addr_i[AddrWidth-1:2], 2'b00};
        data_we_o    <= lsu_store_i;
        data_be_o    <= be;
        data_wdata_o <= wdata_lane;
      end
      if (state == ST_WAIT && data_rvalid_i && !expired) lsu_rdata_o <= rdata_ext;
    end
  end
endmodule

// File: tb/tb_panda_lsu_bus.sv
// tb_panda_lsu_bus: directed accesses checked cycle by cycle against a timeline model
module tb_panda_lsu_bus;
  import panda_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, store, uns, err_in;
  lsu_width_e  width;
  logic [31:0] addr, wdata, rdata;
  logic        d_req, d_gnt, d_rv, t_req, t_gnt, t_rv;
  logic [31:0] d_rdata, t_rdata, d_addr, t_addr, d_wd, t_wd;
  logic        d_done, t_done, d_stall, t_stall, d_err, t_err, d_breq, t_breq, d_we, t_we;
  logic [3:0]  d_be, t_be;
  lsu_err_e    d_cause, t_cause;
  panda_lsu_bus dut (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(d_req), .lsu_store_i(store), .lsu_width_i(width),
    .lsu_load_unsigned_i(uns), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_rdata_o(d_rdata),
    .lsu_done_o(d_done), .lsu_stall_o(d_stall), .lsu_err_o(d_err), .lsu_err_cause_o(d_cause),
    .data_req_o(d_breq), .data_gnt_i(d_gnt), .data_addr_o(d_addr), .data_we_o(d_we),
    .data_be_o(d_be), .data_wdata_o(d_wd), .data_rvalid_i(d_rv), .data_rdata_i(rdata),
    .data_err_i(err_in)
  );
  panda_lsu_bus #(.AddrWidth(32), .TimeoutCycles(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(t_req), .lsu_store_i(store), .lsu_width_i(width),
    .lsu_load_unsigned_i(uns), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_rdata_o(t_rdata),
    .lsu_done_o(t_done), .lsu_stall_o(t_stall), .lsu_err_o(t_err), .lsu_err_cause_o(t_cause),
    .data_req_o(t_breq), .data_gnt_i(t_gnt), .data_addr_o(t_addr), .data_we_o(t_we),
    .data_be_o(t_be), .data_wdata_o(t_wd), .data_rvalid_i(t_rv), .data_rdata_i(rdata),
    .data_err_i(err_in)
  );
  logic        sel;
  logic        o_done, o_stall, o_err, o_breq, o_we, cur_req;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;
  logic [1:0]  o_cause;
  assign o_done  = sel ? t_done : d_done;
  assign o_stall = sel ? t_stall : d_stall;
  assign o_err   = sel ? t_err : d_err;
  assign o_breq  = sel ? t_breq : d_breq;
  assign o_we    = sel ? t_we : d_we;
  assign o_rdata = sel ? t_rdata : d_rdata;
  assign o_addr  = sel ? t_addr : d_addr;
  assign o_wd    = sel ? t_wd : d_wd;
  assign o_be    = sel ? t_be : d_be;
  assign o_cause = sel ? t_cause : d_cause;
  assign cur_req = sel ? t_req : d_req;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // model of the access rules: lane mask, replicated store data, extracted load value
  function automatic int sz(input lsu_width_e w);
    return (w == LSU_BYTE) ? 1 : (w == LSU_HALF) ? 2 : 4;
  endfunction
  function automatic logic [3:0] m_be(input lsu_width_e w, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    for (int i = 0; i < 4; i++) m_be[i] = (i >= o) && (i < o + sz(w));
  endfunction
  function automatic logic [31:0] m_lane(input lsu_width_e w, input logic [31:0] d);
    for (int i = 0; i < 4; i++) m_lane[8*i +: 8] = d[8*(i % sz(w)) +: 8];
  endfunction
  function automatic logic [31:0] m_load(input lsu_width_e w, input logic u, input logic [31:0] a, input logic [31:0] d);
    longint v, n;
    n = longint'(1) << (8 * sz(w));
    v = longint'(d >> (8 * int'(a[1:0]))) & (n - 1);
    if (!u && v >= n / 2) v = v - n;
    return v[31:0];
  endfunction
  bit          chk_on, active, chain, exp_store, in_win;
  int          cyc, exp_done, exp_req_hi, cap_done;
  logic [31:0] exp_addr, exp_wdata, exp_rdata, cap_rdata, cap_addr, cap_wd;
  logic [3:0]  exp_be, cap_be;
  lsu_err_e    exp_cause;
  logic [1:0]  cap_cause;
  always @(negedge clk) if (chk_on) begin
    if (active) begin
      in_win = cyc >= 1 && cyc <= exp_req_hi;
      chk("done", 32'(o_done), 32'(cyc == exp_done));
      chk("stall", 32'(o_stall), 32'(cur_req && cyc != exp_done));
      chk("data_req", 32'(o_breq), 32'(in_win));
      if (in_win) begin
        chk("addr", o_addr, exp_addr);
        chk("be", 32'(o_be), 32'(exp_be));
        chk("we", 32'(o_we), 32'(exp_store));
        if (exp_store) chk("wdata", o_wd, exp_wdata);
        cap_addr = o_addr;
        cap_be = o_be;
        cap_wd = o_wd;
      end
      if (o_done) cap_done = cyc;
      if (cyc == exp_done) begin
        chk("err", 32'(o_err), 32'(exp_cause != ERR_NONE));
        chk("cause", 32'(o_cause), 32'(exp_cause));
        if (!exp_store && exp_cause == ERR_NONE) chk("rdata", o_rdata, exp_rdata);
        cap_rdata = o_rdata;
        cap_cause = o_cause;
      end
      cyc++;
    end else begin
      chk("idle_done", 32'(o_done), 32'(0));
      chk("idle_req", 32'(o_breq), 32'(0));
    end
  end
  // gw<0: grant never comes; rst_at>=0: reset pulsed in that cycle, access never retires
  task automatic run(input bit s, input bit st, input lsu_width_e w, input bit u,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input bit e,
                     input int gw, input int rw, input bit early, input int rst_at, input bit b2b);
    int to, g, r, last;
    bit reqv, gv, rvv;
    to = s ? 4 : 255;
    g = (gw < 0) ? 1000 : 1 + gw;
    r = g + 1 + rw;
    if (!chain) begin
      @(posedge clk);
      #1;
    end
    sel = s; store = st; width = w; uns = u; addr = a; wdata = wd;
    exp_store = st;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be = m_be(w, a);
    exp_wdata = m_lane(w, wd);
    exp_rdata = m_load(w, u, a, rd);
    if (int'(a[1:0]) % sz(w) != 0) begin
      exp_req_hi = 0; exp_done = 1; exp_cause = ERR_MISALIGNED;
    end else if (r >= to) begin
      exp_req_hi = (g < to) ? g : to; exp_done = to + 1; exp_cause = ERR_TIMEOUT;
    end else begin
      exp_req_hi = g; exp_done = r + 1; exp_cause = e ? ERR_BUS : ERR_NONE;
    end
    if (rst_at >= 0) exp_done = -1;
    last = (rst_at >= 0) ? rst_at + 3 : b2b ? exp_done : exp_done + 2;
    cap_done = -1;
    cyc = 0;
    active = 1;
    for (int k = 0; k <= last; k++) begin
      reqv = (rst_at >= 0) ? k <= rst_at : k <= exp_done;
      gv = k == g;
      rvv = k == r || (early && k == g) || k == exp_done + 1 || (rst_at >= 0 && k == rst_at + 1);
      rdata = (early && k == g) ? ~rd : rd;
      err_in = e;
      rst = k == rst_at;
      d_req = !s && reqv; t_req = s && reqv;
      d_gnt = !s && gv;   t_gnt = s && gv;
      d_rv = !s && rvv;   t_rv = s && rvv;
      @(posedge clk);
      #1;
    end
    active = 0;
    rst = 0;
    {d_req, t_req, d_gnt, t_gnt, d_rv, t_rv} = '0;
    chain = b2b;
  endtask
  initial begin
    {chk_on, active, chain, sel} = '0;
    {d_req, t_req, d_gnt, t_gnt, d_rv, t_rv, store, uns, err_in} = '0;
    width = LSU_WORD; addr = '0; wdata = '0; rdata = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(d_breq), 32'(0));
    chk("rst_we", 32'(d_we), 32'(0));
    chk("rst_be", 32'(d_be), 32'(0));
    chk("rst_addr", d_addr, 32'(0));
    chk("rst_wdata", d_wd, 32'(0));
    chk("rst_rdata", d_rdata, 32'(0));
    chk("rst_done", 32'(d_done), 32'(0));
    chk("rst_err", 32'(d_err), 32'(0));
    chk("rst_cause", 32'(d_cause), 32'(ERR_NONE));
    chk("rst_to_req", 32'(t_breq), 32'(0));
    @(posedge clk);
    #1 rst = 0;
    chk_on = 1;
    run(0, 1, LSU_WORD, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, -1, 0);
    chk("t1_be", 32'(cap_be), 32'hF);
    chk("t1_addr", cap_addr, 32'h100);
    chk("t1_wdata", cap_wd, 32'hDEADBEEF);
    chk("t1_done_cyc", 32'(cap_done), 32'd3);
    chk("t1_cause", 32'(cap_cause), 32'(ERR_NONE));
    run(0, 0, LSU_BYTE, 0, 32'h103, 32'h0, 32'h80FF_FF00, 0, 2, 1, 0, -1, 0);
    chk("t2_rdata", cap_rdata, 32'hFFFFFF80);
    chk("t2_done_cyc", 32'(cap_done), 32'd6);
    run(0, 0, LSU_BYTE, 1, 32'h103, 32'h0, 32'h80FF_FF00, 0, 2, 1, 0, -1, 0);
    chk("t3_rdata", cap_rdata, 32'h00000080);
    run(0, 1, LSU_HALF, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 1, 2, 0, -1, 0);
    chk("t4_be", 32'(cap_be), 32'hC);
    chk("t4_wdata", cap_wd, 32'hABCDABCD);
    chk("t4_addr", cap_addr, 32'h200);
    run(0, 0, LSU_WORD, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0, -1, 0);
    chk("t5_done_cyc", 32'(cap_done), 32'd1);
    chk("t5_cause", 32'(cap_cause), 32'(ERR_MISALIGNED));
    run(1, 0, LSU_WORD, 0, 32'h40, 32'h0, 32'h1111_2222, 0, -1, 0, 0, -1, 0);
    chk("t6_done_cyc", 32'(cap_done), 32'd5);
    chk("t6_cause", 32'(cap_cause), 32'(ERR_TIMEOUT));
    run(0, 0, LSU_HALF, 0, 32'h12, 32'h0, 32'h8001_0000, 1, 1, 0, 0, -1, 0);
    chk("t7_cause", 32'(cap_cause), 32'(ERR_BUS));
    run(0, 0, LSU_BYTE, 1, 32'h21, 32'h0, 32'h0000_A500, 0, 0, 1, 1, -1, 0);
    chk("t8_rdata", cap_rdata, 32'h000000A5);
    run(0, 0, LSU_HALF, 0, 32'h36, 32'h0, 32'h9ABC_0000, 0, 0, 0, 0, -1, 0);
    chk("t9_rdata", cap_rdata, 32'hFFFF9ABC);
    run(0, 1, LSU_WORD, 0, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0, 10, 0, 3, 0);
    chk("t10_no_done", 32'(cap_done), 32'hFFFFFFFF);
    run(0, 0, LSU_WORD, 0, 32'h8, 32'h0, 32'h7654_3210, 0, 0, 0, 0, -1, 1);
    run(0, 1, LSU_BYTE, 0, 32'h5, 32'h0000_0077, 32'h0, 0, 0, 0, 0, -1, 0);
    chk("t11_wdata", cap_wd, 32'h77777777);
    chk("t11_be", 32'(cap_be), 32'h2);
    chk("t11_done_cyc", 32'(cap_done), 32'd3);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
